// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - big-endian load/store master with read-modify-write sub-word stores
// Optional LSU_MISALIGN_TRAP_EN: trap misaligned accesses instead of forcing alignment.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  ResetN,
    input  logic                  Start,
    input  logic                  IsStore,
    input  logic [1:0]            Size,
    input  logic                  SignExtend,
    input  logic [ADDR_WIDTH-1:0] ReqAddress,
    input  logic [31:0]           StoreData,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error,
    output logic [31:0]           LoadData,
    output logic                  MemoryRead,
    output logic                  MemoryWrite,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [31:0]           MemWriteData,
    input  logic [31:0]           MemReadData
);
    typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPTURE, S_WRITE, S_RESP} state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_is_store;
    logic                  r_sign;
    logic [1:0]            r_size;
    logic [1:0]            r_offset;
    logic [ADDR_WIDTH-1:0] r_address;
    logic [31:0]           r_wdata;
    logic [31:0]           r_load_data;
    logic                  w_start;
    logic                  w_word;
    logic                  w_misaligned;
    logic [1:0]            w_offset;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_load_ext;
    logic [31:0]           w_merge;

    assign w_start = (r_state == S_IDLE) && Start;
    assign w_word  = Size[1];

`ifdef LSU_MISALIGN_TRAP_EN
    logic r_error;

    assign w_misaligned = (Size == 2'b01 && ReqAddress[0]) || (w_word && ReqAddress[1:0] != 2'b00);
    assign w_offset     = ReqAddress[1:0];
    assign Error        = (r_state == S_RESP) && r_error;

    always_ff @(posedge clock or negedge ResetN) begin
        if (!ResetN)
            r_error <= 1'b0;
        else if (w_start)
            r_error <= w_misaligned;
    end
`else
    // Without trapping, the low address bits below the access size are simply dropped.
    assign w_misaligned = 1'b0;
    assign w_offset     = w_word ? 2'b00 : (Size[0] ? {ReqAddress[1], 1'b0} : ReqAddress[1:0]);
    assign Error        = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    if (w_misaligned)
                        w_next = S_RESP;
                    else if (IsStore && w_word)
                        w_next = S_WRITE;
                    else
                        w_next = S_READ;
                end
            end
            S_READ:    w_next = S_CAPTURE;
            S_CAPTURE: w_next = r_is_store ? S_WRITE : S_RESP;
            S_WRITE:   w_next = S_RESP;
            S_RESP:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Lane select and merge; r_wdata still holds the right-justified store data until CAPTURE.
    always_comb begin
        w_byte = 8'h00;
        case (r_offset)
            2'd0:    w_byte = MemReadData[31:24];
            2'd1:    w_byte = MemReadData[23:16];
            2'd2:    w_byte = MemReadData[15:8];
            default: w_byte = MemReadData[7:0];
        endcase
        w_half = r_offset[1] ? MemReadData[15:0] : MemReadData[31:16];

        w_load_ext = MemReadData;
        w_merge    = r_wdata;
        if (!r_size[1] && r_size[0]) begin
            w_load_ext = {{16{r_sign & w_half[15]}}, w_half};
            w_merge    = r_offset[1] ? {MemReadData[31:16], r_wdata[15:0]}
                                     : {r_wdata[15:0], MemReadData[15:0]};
        end else if (!r_size[1]) begin
            w_load_ext = {{24{r_sign & w_byte[7]}}, w_byte};
            case (r_offset)
                2'd0:    w_merge = {r_wdata[7:0], MemReadData[23:0]};
                2'd1:    w_merge = {MemReadData[31:24], r_wdata[7:0], MemReadData[15:0]};
                2'd2:    w_merge = {MemReadData[31:16], r_wdata[7:0], MemReadData[7:0]};
                default: w_merge = {MemReadData[31:8], r_wdata[7:0]};
            endcase
        end
    end

    always_ff @(posedge clock or negedge ResetN) begin
        if (!ResetN) begin
            r_state     <= S_IDLE;
            r_is_store  <= 1'b0;
            r_sign      <= 1'b0;
            r_size      <= 2'b00;
            r_offset    <= 2'b00;
            r_address   <= '0;
            r_wdata     <= 32'h0;
            r_load_data <= 32'h0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_is_store <= IsStore;
                r_sign     <= SignExtend;
                r_size     <= Size;
                r_offset   <= w_offset;
                r_address  <= {ReqAddress[ADDR_WIDTH-1:2], 2'b00};
                r_wdata    <= StoreData;
            end
            if (r_state == S_CAPTURE) begin
                if (r_is_store)
                    r_wdata <= w_merge;
                else
                    r_load_data <= w_load_ext;
            end
        end
    end

    assign Busy         = (r_state != S_IDLE);
    assign Done         = (r_state == S_RESP);
    assign MemoryRead   = (r_state == S_READ);
    assign MemoryWrite  = (r_state == S_WRITE);
    assign Address      = r_address;
    assign MemWriteData = r_wdata;
    assign LoadData     = r_load_data;
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit with a word-memory model
module tb_load_store_unit;
    logic        clock = 1'b0;
    logic        ResetN = 1'b0;
    logic        Start = 1'b0;
    logic        IsStore = 1'b0;
    logic [1:0]  Size = 2'b00;
    logic        SignExtend = 1'b0;
    logic [31:0] ReqAddress = 32'h0;
    logic [31:0] StoreData = 32'h0;
    logic        Busy, Done, Error, MemoryRead, MemoryWrite;
    logic [31:0] LoadData, Address, MemWriteData;
    logic [31:0] MemReadData = 32'h0;

    logic [31:0] mem [0:63] = '{default: 32'h0};
    logic [31:0] ref_mem [0:63] = '{default: 32'h0};
    logic [31:0] exp_ld;
    int n_checks = 0;
    int n_errors = 0;

    int          obs_lat, obs_rd, obs_wr;
    logic [31:0] obs_rd_addr, obs_wr_addr, obs_wr_data;
    logic        obs_err, obs_busy_ok, obs_idle_ok, obs_stray_err;

    load_store_unit #(.ADDR_WIDTH(32)) dut (
        .clock(clock), .ResetN(ResetN), .Start(Start), .IsStore(IsStore), .Size(Size),
        .SignExtend(SignExtend), .ReqAddress(ReqAddress), .StoreData(StoreData),
        .Busy(Busy), .Done(Done), .Error(Error), .LoadData(LoadData),
        .MemoryRead(MemoryRead), .MemoryWrite(MemoryWrite), .Address(Address),
        .MemWriteData(MemWriteData), .MemReadData(MemReadData)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (MemoryRead) MemReadData <= mem[Address[7:2]];
        if (MemoryWrite) mem[Address[7:2]] <= MemWriteData;
    end

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
    endfunction

    function automatic bit is_mis(input logic [1:0] sz, input int off);
`ifdef LSU_MISALIGN_TRAP_EN
        return (off % nbytes(sz)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] lane_mask(input int nb);
        return (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
    endfunction

    function automatic int lane_shift(input logic [1:0] sz, input int off);
        int nb = nbytes(sz);
        return 8 * (4 - nb - (off - (off % nb)));
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] sz, input int off, input logic sx);
        int nb = nbytes(sz);
        logic [31:0] mask = lane_mask(nb);
        logic [31:0] v = (w >> lane_shift(sz, off)) & mask;
        if (sx && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] m_store(input logic [31:0] w, input logic [1:0] sz, input int off, input logic [31:0] d);
        logic [31:0] mask = lane_mask(nbytes(sz));
        int sh = lane_shift(sz, off);
        return (w & ~(mask << sh)) | ((d & mask) << sh);
    endfunction

    task automatic run_op(input logic st, input logic [1:0] sz, input logic sx, input logic [7:0] a, input logic [31:0] d);
        @(negedge clock);
        IsStore = st; Size = sz; SignExtend = sx; ReqAddress = {24'h0, a}; StoreData = d; Start = 1'b1;
        @(negedge clock);
        Start = 1'b0;
        obs_lat = 0; obs_rd = 0; obs_wr = 0; obs_err = 1'b0; obs_busy_ok = 1'b1; obs_stray_err = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (MemoryRead) begin obs_rd++; obs_rd_addr = Address; end
            if (MemoryWrite) begin obs_wr++; obs_wr_addr = Address; obs_wr_data = MemWriteData; end
            if (!Busy) obs_busy_ok = 1'b0;
            if (Error && !Done) obs_stray_err = 1'b1;
            if (Done) begin obs_lat = c; obs_err = Error; break; end
            @(negedge clock);
        end
        @(negedge clock);
        obs_idle_ok = !Busy && !Done && !Error;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        n_checks++; if ({Busy, Done, Error, MemoryRead, MemoryWrite} !== 5'b0) begin n_errors++; $display("FAIL reset_ctrl got %b exp 00000", {Busy, Done, Error, MemoryRead, MemoryWrite}); end
        n_checks++; if (Address !== 32'h0 || MemWriteData !== 32'h0) begin n_errors++; $display("FAIL reset_addr_data got %h/%h exp 0/0", Address, MemWriteData); end
        n_checks++; if (LoadData !== 32'h0) begin n_errors++; $display("FAIL reset_loaddata got %h exp 0", LoadData); end
        ResetN = 1'b1;
    endtask

    task automatic test_directed();
        run_op(1'b1, 2'd2, 1'b0, 8'h10, 32'hDEADBEEF);
        n_checks++; if (obs_lat !== 2) begin n_errors++; $display("FAIL wstore_lat got %0d exp 2", obs_lat); end
        n_checks++; if (obs_wr !== 1 || obs_rd !== 0) begin n_errors++; $display("FAIL wstore_traffic got wr=%0d rd=%0d exp 1/0", obs_wr, obs_rd); end
        n_checks++; if (obs_wr_addr !== 32'h10 || obs_wr_data !== 32'hDEADBEEF) begin n_errors++; $display("FAIL wstore_bus got %h/%h exp 10/deadbeef", obs_wr_addr, obs_wr_data); end
        run_op(1'b0, 2'd2, 1'b0, 8'h10, 32'h0);
        n_checks++; if (obs_lat !== 3) begin n_errors++; $display("FAIL wload_lat got %0d exp 3", obs_lat); end
        n_checks++; if (LoadData !== 32'hDEADBEEF || obs_rd_addr !== 32'h10) begin n_errors++; $display("FAIL wload_data got %h @%h exp deadbeef @10", LoadData, obs_rd_addr); end

        run_op(1'b1, 2'd2, 1'b0, 8'h20, 32'h80F17F02);
        run_op(1'b0, 2'd0, 1'b1, 8'h20, 32'h0);
        n_checks++; if (LoadData !== 32'hFFFFFF80) begin n_errors++; $display("FAIL lb_signed got %h exp ffffff80", LoadData); end
        run_op(1'b0, 2'd0, 1'b0, 8'h20, 32'h0);
        n_checks++; if (LoadData !== 32'h00000080) begin n_errors++; $display("FAIL lb_unsigned got %h exp 00000080", LoadData); end
        run_op(1'b0, 2'd0, 1'b1, 8'h22, 32'h0);
        n_checks++; if (LoadData !== 32'h0000007F) begin n_errors++; $display("FAIL lb_off2 got %h exp 0000007f", LoadData); end

        run_op(1'b1, 2'd2, 1'b0, 8'h30, 32'h11223344);
        run_op(1'b1, 2'd1, 1'b0, 8'h32, 32'h0000ABCD);
        n_checks++; if (obs_lat !== 4 || obs_rd !== 1 || obs_wr !== 1) begin n_errors++; $display("FAIL sh_rmw_seq got lat=%0d rd=%0d wr=%0d exp 4/1/1", obs_lat, obs_rd, obs_wr); end
        n_checks++; if (obs_wr_data !== 32'h1122ABCD) begin n_errors++; $display("FAIL sh_rmw_data got %h exp 1122abcd", obs_wr_data); end

        run_op(1'b1, 2'd2, 1'b0, 8'h30, 32'h11223344);
        run_op(1'b1, 2'd0, 1'b0, 8'h31, 32'h0000005A);
        n_checks++; if (obs_wr_data !== 32'h115A3344) begin n_errors++; $display("FAIL sb_rmw_data got %h exp 115a3344", obs_wr_data); end
        run_op(1'b0, 2'd2, 1'b0, 8'h30, 32'h0);
        n_checks++; if (LoadData !== 32'h115A3344) begin n_errors++; $display("FAIL sb_readback got %h exp 115a3344", LoadData); end

        run_op(1'b1, 2'd2, 1'b0, 8'h40, 32'hCAFEF00D);
        run_op(1'b0, 2'd2, 1'b0, 8'h41, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        exp_ld = 32'h115A3344;
        n_checks++; if (obs_lat !== 1 || obs_err !== 1'b1 || obs_rd !== 0) begin n_errors++; $display("FAIL misaligned got lat=%0d err=%b rd=%0d exp 1/1/0", obs_lat, obs_err, obs_rd); end
`else
        exp_ld = 32'hCAFEF00D;
        n_checks++; if (obs_lat !== 3 || obs_err !== 1'b0 || obs_rd_addr !== 32'h40) begin n_errors++; $display("FAIL forced_align got lat=%0d err=%b addr=%h exp 3/0/40", obs_lat, obs_err, obs_rd_addr); end
`endif
        n_checks++; if (LoadData !== exp_ld) begin n_errors++; $display("FAIL misaligned_ld got %h exp %h", LoadData, exp_ld); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 320; i++) begin
            logic st = 1'($urandom_range(0, 1));
            logic [1:0] sz = 2'($urandom_range(0, 3));
            logic sx = 1'($urandom_range(0, 1));
            logic [7:0] a = 8'($urandom_range(0, 255));
            logic [31:0] d = $urandom;
            logic [31:0] w;
            int off, exp_lat, exp_rd, exp_wr;
            bit mis;
            if (i < 64) begin st = 1'b1; sz = 2'd2; a = 8'(i * 4); end
            w = ref_mem[a[7:2]];
            off = int'(a[1:0]);
            mis = is_mis(sz, off);
            exp_lat = mis ? 1 : (!st ? 3 : (nbytes(sz) == 4 ? 2 : 4));
            exp_rd = (!mis && (!st || nbytes(sz) < 4)) ? 1 : 0;
            exp_wr = (!mis && st) ? 1 : 0;
            run_op(st, sz, sx, a, d);
            n_checks++; if (obs_lat !== exp_lat) begin n_errors++; $display("FAIL rnd_lat[%0d] got %0d exp %0d", i, obs_lat, exp_lat); end
            n_checks++; if (obs_rd !== exp_rd || obs_wr !== exp_wr) begin n_errors++; $display("FAIL rnd_traffic[%0d] got rd=%0d wr=%0d exp %0d/%0d", i, obs_rd, obs_wr, exp_rd, exp_wr); end
            n_checks++; if (obs_err !== mis || obs_stray_err !== 1'b0) begin n_errors++; $display("FAIL rnd_error[%0d] got %b stray=%b exp %b", i, obs_err, obs_stray_err, mis); end
            n_checks++; if (!obs_busy_ok || !obs_idle_ok) begin n_errors++; $display("FAIL rnd_busy[%0d] got busy_ok=%b idle_ok=%b exp 1/1", i, obs_busy_ok, obs_idle_ok); end
            if (exp_rd == 1) begin
                n_checks++; if (obs_rd_addr !== {24'h0, a[7:2], 2'b00}) begin n_errors++; $display("FAIL rnd_rd_addr[%0d] got %h exp %h", i, obs_rd_addr, {24'h0, a[7:2], 2'b00}); end
            end
            if (exp_wr == 1) begin
                ref_mem[a[7:2]] = m_store(w, sz, off, d);
                n_checks++; if (obs_wr_addr !== {24'h0, a[7:2], 2'b00} || obs_wr_data !== ref_mem[a[7:2]]) begin n_errors++; $display("FAIL rnd_write[%0d] got %h@%h exp %h", i, obs_wr_data, obs_wr_addr, ref_mem[a[7:2]]); end
            end
            if (!st && !mis) exp_ld = m_load(w, sz, off, sx);
            n_checks++; if (LoadData !== exp_ld) begin n_errors++; $display("FAIL rnd_load[%0d] got %h exp %h", i, LoadData, exp_ld); end
        end
    endtask

    task automatic test_busy_start();
        logic [7:0] a = 8'($urandom_range(0, 63) * 4 + 1);
        logic [31:0] d = $urandom;
        int dones = 0, wrs = 0;
        ref_mem[a[7:2]] = m_store(ref_mem[a[7:2]], 2'd0, 1, d);
        @(negedge clock);
        IsStore = 1'b1; Size = 2'd0; ReqAddress = {24'h0, a}; StoreData = d; Start = 1'b1;
        @(negedge clock);
        IsStore = 1'b0; Size = 2'd2; ReqAddress = 32'h0;
        for (int c = 1; c <= 10; c++) begin
            if (c == 5) Start = 1'b0;
            if (Done) dones++;
            if (MemoryWrite) wrs++;
            @(negedge clock);
        end
        n_checks++; if (dones !== 1 || wrs !== 1) begin n_errors++; $display("FAIL busy_start got dones=%0d writes=%0d exp 1/1", dones, wrs); end
        n_checks++; if (mem[a[7:2]] !== ref_mem[a[7:2]]) begin n_errors++; $display("FAIL busy_mem got %h exp %h", mem[a[7:2]], ref_mem[a[7:2]]); end
    endtask

    task automatic test_reset_mid();
        int wrs = 0;
        @(negedge clock);
        IsStore = 1'b1; Size = 2'd0; ReqAddress = 32'h15; StoreData = 32'hA5; Start = 1'b1;
        @(negedge clock);
        Start = 1'b0;
        n_checks++; if (MemoryRead !== 1'b1) begin n_errors++; $display("FAIL rstmid_read got %b exp 1", MemoryRead); end
        @(negedge clock);
        ResetN = 1'b0;
        #1;
        n_checks++; if ({Busy, Done, Error, MemoryRead, MemoryWrite} !== 5'b0 || Address !== 32'h0 || MemWriteData !== 32'h0 || LoadData !== 32'h0) begin
            n_errors++; $display("FAIL rstmid_outputs got ctrl=%b addr=%h wd=%h ld=%h exp all 0", {Busy, Done, Error, MemoryRead, MemoryWrite}, Address, MemWriteData, LoadData); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (MemoryWrite) wrs++;
        end
        ResetN = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            if (MemoryWrite) wrs++;
        end
        n_checks++; if (wrs !== 0 || mem[5] !== ref_mem[5]) begin n_errors++; $display("FAIL rstmid_nowrite got writes=%0d mem=%h exp 0/%h", wrs, mem[5], ref_mem[5]); end
        run_op(1'b0, 2'd2, 1'b0, 8'h14, 32'h0);
        n_checks++; if (LoadData !== ref_mem[5]) begin n_errors++; $display("FAIL rstmid_reload got %h exp %h", LoadData, ref_mem[5]); end
    endtask

    initial begin
        exp_ld = 32'h0;
        test_reset();
        test_directed();
        test_random();
        test_busy_start();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator-side master for the byte-addressed, big-endian data memory. Takes one load/store request at a time from the MIPS datapath and drives the memory's MemoryRead/MemoryWrite/Address/InputData port. It performs byte-lane extraction with sign or zero extension on loads. Because the memory only writes whole words, byte and halfword stores are done as read-modify-write sequences.

## Interface
- ADDR_WIDTH, 32, width of request and memory addresses
- clock  in  1  rising-edge clock shared with the data memory
- ResetN  in  1  asynchronous, active-low reset
- Start  in  1  request strobe, sampled only in IDLE
- IsStore  in  1  1 = store, 0 = load
- Size  in  2  00 byte, 01 halfword, 10 word; 11 is treated as word
- SignExtend  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- ReqAddress  in  ADDR_WIDTH  byte address of the request
- StoreData  in  32  store data, right-justified for byte and halfword
- Busy  out  1  high whenever state is not IDLE
- Done  out  1  one-cycle completion pulse
- Error  out  1  valid with Done; misaligned request, no memory access made
- LoadData  out  32  extended load result; holds until the next load completes
- MemoryRead  out  1  memory read enable
- MemoryWrite  out  1  memory write enable
- Address  out  ADDR_WIDTH  word-aligned memory address, {ReqAddress[ADDR_WIDTH-1:2], 2'b00}
- MemWriteData  out  32  word driven to the memory InputData
- MemReadData  in  32  memory OutputData, registered by the memory

## Operation
- States: IDLE, READ, CAPTURE, WRITE, RESP.
- In IDLE, Start=1 latches IsStore, Size, SignExtend, ReqAddress and StoreData.
- Next state after IDLE:
  - misaligned request → RESP with Error=1
  - load → READ
  - word store → WRITE
  - byte/halfword store → READ
- READ → CAPTURE → then RESP for a load, WRITE for a store. RESP → IDLE.
- WRITE → RESP.
- Misaligned means: halfword with offset[0]=1, or word with offset≠0, where offset = ReqAddress[1:0].
- Lane mapping is big-endian:
  - byte offset k occupies bits [31-8k -: 8]
  - halfword offset 0 occupies [31:16]; offset 2 occupies [15:0]
- Loads: on leaving CAPTURE, select the lane from MemReadData, extend it to 32 bits per SignExtend, and register it into LoadData. A word load ignores SignExtend.
- Sub-word stores: in CAPTURE, register the merge word, i.e. MemReadData with the target lane replaced by StoreData[7:0] or StoreData[15:0]. Word stores use StoreData directly.
- Start is ignored while Busy. Requests are never queued.
- Error=1 only together with Done; Error is 0 in all other cycles.

## Timing
- All outputs are registered or pure decodes of the state register. There are no combinational paths from inputs to outputs.
- MemoryRead=1 exactly during READ, and MemoryWrite=1 exactly during WRITE, each for one cycle. Address is valid in those cycles.
- The memory samples at the edge ending READ. MemReadData is valid during CAPTURE and is sampled at the edge ending CAPTURE.
- Latency from the edge that samples Start to the cycle with Done=1:
  - load: 3 cycles
  - word store: 2 cycles
  - byte/halfword store: 4 cycles
  - misaligned: 1 cycle
- The earliest next Start is sampled in the cycle after RESP; Busy is 0 in that cycle.
- Reset values: state IDLE; Busy, Done, Error, MemoryRead, MemoryWrite = 0; Address, MemWriteData, LoadData = 0.
- Reset mid-operation: everything returns to IDLE immediately and the request is abandoned. A store whose WRITE cycle is cut by reset may not land; no partial merge is ever written.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: misaligned requests are detected, produce Done with Error=1, and cause no memory traffic.
- LSU_MISALIGN_TRAP_EN undefined:
  - no misalignment check; Error is tied to 0
  - halfword accesses ignore ReqAddress[0]
  - word accesses ignore ReqAddress[1:0]
  - the access proceeds on the forced-aligned lane

## Test plan
- Word store then load: store 0xDEADBEEF to 0x10, then load word from 0x10 → one MemoryWrite with Address=0x10, Data=0xDEADBEEF; load returns LoadData=0xDEADBEEF with Done 3 cycles after Start.
- Byte loads: memory word 0x80F1_7F02 at 0x20. Load byte from 0x20 with SignExtend=1 → 0xFFFFFF80. SignExtend=0 → 0x00000080. Load byte from 0x22 signed → 0x0000007F.
- Halfword store RMW: memory word 0x11223344 at 0x30; store halfword 0xABCD to 0x32 → READ, CAPTURE, then one write of 0x1122ABCD; Done 4 cycles after Start.
- Byte store RMW: store 0x5A to 0x31 over 0x11223344 → write of 0x115A3344; the other lanes are unchanged on readback.
- Misaligned: with the macro defined, load word from 0x41 → Done and Error in the next cycle, MemoryRead never asserted. Without the macro, the same access reads 0x40 and Error stays 0.
- Reset and busy handling: deassert ResetN during CAPTURE of a byte store → MemoryWrite never asserts and all outputs read 0. Separately, a Start pulsed while Busy is ignored, and exactly one Done is produced.
